// File: rtl/riscv_wb_pkg.sv
// Shared types and constants for the RISC-V write-back stage.
// Optional feature macro: RISCV_WB_DMEM_TIMEOUT_EN (data-memory response timeout).
package riscv_wb_pkg;

  localparam int unsigned ILEN           = 32;
  localparam int unsigned EXCEPTION_SIZE = 16;

  localparam int unsigned EXC_LOAD_ACCESS_FAULT  = 5;
  localparam int unsigned EXC_STORE_ACCESS_FAULT = 7;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  // Opcodes that produce a register-file result.
  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM: writes_rd = 1'b1;
      default:                                  writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_wb_if.sv
// MEM->WB, data-memory response and register-file write signals of the write-back stage.
// master drives the MEM/dmem side; slave is the write-back stage itself.
interface riscv_wb_if
  import riscv_wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) ();

  logic [XLEN-1:0]           mem_pc;
  logic [ILEN-1:0]           mem_instr;
  logic                      mem_bubble;
  logic [EXCEPTION_SIZE-1:0] mem_exception;
  logic [XLEN-1:0]           mem_r;
  logic [XLEN-1:0]           mem_memadr;

  logic                      dmem_ack;
  logic                      dmem_err;
  logic [XLEN-1:0]           dmem_q;

  logic                      wb_stall;
  logic [XLEN-1:0]           wb_pc;
  logic [ILEN-1:0]           wb_instr;
  logic                      wb_bubble;
  logic [EXCEPTION_SIZE-1:0] wb_exception;
  logic                      wb_we;
  logic [4:0]                wb_dst;
  logic [XLEN-1:0]           wb_r;

  modport master (
    output mem_pc, mem_instr, mem_bubble, mem_exception, mem_r, mem_memadr,
    output dmem_ack, dmem_err, dmem_q,
    input  wb_stall, wb_pc, wb_instr, wb_bubble, wb_exception, wb_we, wb_dst, wb_r
  );

  modport slave (
    input  mem_pc, mem_instr, mem_bubble, mem_exception, mem_r, mem_memadr,
    input  dmem_ack, dmem_err, dmem_q,
    output wb_stall, wb_pc, wb_instr, wb_bubble, wb_exception, wb_we, wb_dst, wb_r
  );

endinterface

// File: rtl/riscv_wb_ldalign.sv
// Load data alignment: picks the addressed byte/half-word lane and sign/zero-extends it.
module riscv_wb_ldalign
  import riscv_wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      adr,
  input  logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane selection; half-words only look at adr[1].
  always_comb begin
    byte_c = q[7:0];
    case (adr)
      2'd0:    byte_c = q[7:0];
      2'd1:    byte_c = q[15:8];
      2'd2:    byte_c = q[23:16];
      default: byte_c = q[31:24];
    endcase
    half_c = adr[1] ? q[31:16] : q[15:0];
  end

  always_comb begin
    r_c = q;
    case (funct3)
      F3_LB:   r_c = {{(XLEN-8){byte_c[7]}}, byte_c};
      F3_LBU:  r_c = {{(XLEN-8){1'b0}}, byte_c};
      F3_LH:   r_c = {{(XLEN-16){half_c[15]}}, half_c};
      F3_LHU:  r_c = {{(XLEN-16){1'b0}}, half_c};
      default: r_c = q;
    endcase
  end

endmodule

// File: rtl/riscv_wb.sv
// RISC-V write-back stage: waits for data-memory responses, aligns load data, drives the RF write port.
// Optional macro RISCV_WB_DMEM_TIMEOUT_EN: retire a memory access as faulted after DMEM_TIMEOUT stall cycles.
module riscv_wb
  import riscv_wb_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PC_INIT      = 32'h200,
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  riscv_wb_if.slave   bus
);

  localparam logic [EXCEPTION_SIZE-1:0] LD_FAULT_MASK =
    EXCEPTION_SIZE'(1) << EXC_LOAD_ACCESS_FAULT;
  localparam logic [EXCEPTION_SIZE-1:0] ST_FAULT_MASK =
    EXCEPTION_SIZE'(1) << EXC_STORE_ACCESS_FAULT;

  wb_state_t                 state, state_n;
  logic [6:0]                opcode_c;
  logic [2:0]                funct3_c;
  logic [4:0]                dst_c;
  logic                      is_load_c, is_store_c;
  logic                      squash_c, memop_c, tmo_c, stall_c, fault_c, we_c;
  logic [EXCEPTION_SIZE-1:0] exc_c;
  logic [XLEN-1:0]           ld_r_c, r_c;
  logic                      unused_adr;

  assign opcode_c   = bus.mem_instr[6:0];
  assign funct3_c   = bus.mem_instr[14:12];
  assign dst_c      = bus.mem_instr[11:7];
  assign is_load_c  = (opcode_c == OPC_LOAD);
  assign is_store_c = (opcode_c == OPC_STORE);
  assign unused_adr = ^bus.mem_memadr[XLEN-1:2];

  // A retiring exception flushes MEM, so whatever sits there now is discarded.
  assign squash_c = |bus.wb_exception;
  assign memop_c  = !bus.mem_bubble && ~|bus.mem_exception && !squash_c
                    && (is_load_c || is_store_c);

  assign stall_c     = memop_c && !bus.dmem_ack && !tmo_c;
  assign bus.wb_stall = rstn && stall_c;

`ifdef RISCV_WB_DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(DMEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt, cnt_n;

  // Counts stall cycles of the pending access; reaching DMEM_TIMEOUT releases the stall.
  assign tmo_c = (state == WAIT) && (cnt == CNT_W'(DMEM_TIMEOUT));

  always_comb begin
    cnt_n = '0;
    if (stall_c) cnt_n = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else       cnt <= cnt_n;
  end
`else
  logic unused_tmo;

  assign tmo_c      = 1'b0;
  assign unused_tmo = ^32'(DMEM_TIMEOUT);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (stall_c)  state_n = WAIT;
      WAIT:    if (!stall_c) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  riscv_wb_ldalign #(
    .XLEN (XLEN)
  ) u_ldalign (
    .funct3 (funct3_c),
    .adr    (bus.mem_memadr[1:0]),
    .q      (bus.dmem_q),
    .r_c    (ld_r_c)
  );

  // A timeout is reported exactly like an error response.
  assign fault_c = memop_c && ((bus.dmem_ack && bus.dmem_err) || tmo_c);

  always_comb begin
    exc_c = bus.mem_exception;
    if (fault_c) exc_c = exc_c | (is_load_c ? LD_FAULT_MASK : ST_FAULT_MASK);
  end

  assign r_c  = is_load_c ? ld_r_c : bus.mem_r;
  assign we_c = !bus.mem_bubble && ~|exc_c && (dst_c != 5'd0) && writes_rd(opcode_c);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.wb_pc        <= XLEN'(PC_INIT);
      bus.wb_instr     <= '0;
      bus.wb_bubble    <= 1'b1;
      bus.wb_exception <= '0;
      bus.wb_we        <= 1'b0;
      bus.wb_dst       <= '0;
      bus.wb_r         <= '0;
    end else if (!stall_c) begin
      bus.wb_pc        <= bus.mem_pc;
      bus.wb_instr     <= bus.mem_instr;
      bus.wb_bubble    <= bus.mem_bubble || squash_c;
      bus.wb_exception <= squash_c ? '0 : exc_c;
      bus.wb_we        <= we_c && !squash_c;
      bus.wb_dst       <= dst_c;
      bus.wb_r         <= r_c;
    end
  end

endmodule
